dsd_stream_ctrl: RTL and testbench



---
 rtl/dsd_stream_ctrl_if.sv | 39 +++
 rtl/dsd_stream_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_dsd_stream_ctrl.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/dsd_stream_ctrl_if.sv
// Stream-side bundle of dsd_stream_ctrl: I2S framing/sample inputs and
// gained-sample / status outputs. The controller uses the slave modport.
// Optional macro DSD_STREAM_CTRL_ERRCNT_EN adds the err_count status field.
interface dsd_stream_ctrl_if;
   logic        ws;
   logic        sample_valid;
   logic [23:0] in_L;
   logic [23:0] in_R;
   logic        mute_req;
   logic [23:0] out_L;
   logic [23:0] out_R;
   logic        out_valid;
   logic        locked;
   logic [2:0]  state;
   logic        frame_err;
`ifdef DSD_STREAM_CTRL_ERRCNT_EN
   logic [15:0] err_count;

   modport master (
      output ws, sample_valid, in_L, in_R, mute_req,
      input  out_L, out_R, out_valid, locked, state, frame_err, err_count
   );

   modport slave (
      input  ws, sample_valid, in_L, in_R, mute_req,
      output out_L, out_R, out_valid, locked, state, frame_err, err_count
   );
`else
   modport master (
      output ws, sample_valid, in_L, in_R, mute_req,
      input  out_L, out_R, out_valid, locked, state, frame_err
   );

   modport slave (
      input  ws, sample_valid, in_L, in_R, mute_req,
      output out_L, out_R, out_valid, locked, state, frame_err
   );
`endif
endinterface

// File: rtl/dsd_stream_ctrl.sv
// PCM-to-DSD stream controller: qualifies I2S ws framing, declares lock,
// and applies a click-free linear gain ramp on start, mute and lock loss.
// Everything runs on bclk. Optional macro DSD_STREAM_CTRL_ERRCNT_EN adds a
// saturating 16-bit count of bad frames on the interface (err_count).
module dsd_stream_ctrl #(
   parameter int unsigned FRAME_BCLK  = 64,
   parameter int unsigned FRAME_TOL   = 2,
   parameter int unsigned LOCK_FRAMES = 4,
   parameter int unsigned RAMP_STEP   = 1
) (
   input  logic             bclk,
   input  logic             rst_n,
   dsd_stream_ctrl_if.slave bus
);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      ACQUIRE   = 3'd1,
      RAMP_UP   = 3'd2,
      RUN       = 3'd3,
      RAMP_DOWN = 3'd4,
      MUTED     = 3'd5
   } state_t;

   localparam int unsigned GW        = $clog2(LOCK_FRAMES + 1);
   localparam logic [7:0]  P_MIN     = 8'(FRAME_BCLK - FRAME_TOL);
   localparam logic [7:0]  P_MAX     = 8'(FRAME_BCLK + FRAME_TOL);
   localparam logic [7:0]  P_TIMEOUT = 8'(2 * FRAME_BCLK);
   localparam logic [8:0]  GAIN_FULL = 9'd256;
   localparam logic [8:0]  STEP      = 9'(RAMP_STEP);
   localparam logic [GW-1:0] LOCK_N  = GW'(LOCK_FRAMES);

   state_t          state_q, state_d;
   logic            ws_q;
   logic [7:0]      cnt_q, cnt_d;
   logic            meas_q, meas_d;
   logic [GW-1:0]   good_q, good_d;
   logic            locked_q, locked_d;
   logic            ferr_q;
   logic [8:0]      gain_q, gain_d;
   logic [23:0]     out_l_q, out_r_q;
   logic            ov_q;

   logic            ws_rise;
   logic            in_tol;
   logic            timeout;
   logic            good_frame;
   logic            bad_frame;

   logic signed [32:0] in_l_x, in_r_x, gain_x;
   logic signed [32:0] prod_l, prod_r;
   logic               unused_prod_bits;

   // A measurement is only judged once a previous edge has started it; a
   // timeout ends the measurement so the following edge restarts it.
   assign ws_rise    = bus.ws & ~ws_q;
   assign in_tol     = (cnt_q >= P_MIN) && (cnt_q <= P_MAX);
   assign timeout    = meas_q && !ws_rise && (cnt_q == P_TIMEOUT);
   assign good_frame = ws_rise && meas_q && in_tol;
   assign bad_frame  = (ws_rise && meas_q && !in_tol) || timeout;

   // Period counter, measurement window, good-frame count and lock flag.
   always_comb begin
      cnt_d    = cnt_q;
      meas_d   = meas_q;
      good_d   = good_q;
      locked_d = locked_q;
      if (ws_rise) begin
         cnt_d  = 8'd1;
         meas_d = 1'b1;
      end else if (cnt_q != 8'hFF) begin
         cnt_d = cnt_q + 8'd1;
      end
      if (timeout) begin
         meas_d = 1'b0;
      end
      if (bad_frame) begin
         good_d   = '0;
         locked_d = 1'b0;
      end else if (good_frame) begin
         if (good_q != LOCK_N) begin
            good_d = good_q + GW'(1);
         end
         if ((state_q == ACQUIRE) && (good_d == LOCK_N)) begin
            locked_d = 1'b1;
         end
      end
   end

   // Framing registers.
   always_ff @(posedge bclk or negedge rst_n) begin
      if (!rst_n) begin
         ws_q     <= 1'b0;
         cnt_q    <= '0;
         meas_q   <= 1'b0;
         good_q   <= '0;
         locked_q <= 1'b0;
         ferr_q   <= 1'b0;
      end else begin
         ws_q     <= bus.ws;
         cnt_q    <= cnt_d;
         meas_q   <= meas_d;
         good_q   <= good_d;
         locked_q <= locked_d;
         ferr_q   <= bad_frame;
      end
   end

   // Gain ramp and sequencing FSM; lock decisions use this cycle's lock
   // update so a bad frame landing on the same cycle is never missed.
   always_comb begin
      state_d = state_q;
      gain_d  = gain_q;
      if (bus.sample_valid) begin
         if (state_q == RAMP_UP) begin
            gain_d = (gain_q >= GAIN_FULL - STEP) ? GAIN_FULL : gain_q + STEP;
         end else if (state_q == RAMP_DOWN) begin
            gain_d = (gain_q <= STEP) ? '0 : gain_q - STEP;
         end
      end
      case (state_q)
         IDLE: begin
            if (ws_rise) state_d = ACQUIRE;
         end
         ACQUIRE: begin
            if (locked_d) state_d = bus.mute_req ? MUTED : RAMP_UP;
         end
         RAMP_UP: begin
            if (bad_frame || bus.mute_req) state_d = RAMP_DOWN;
            else if (gain_d == GAIN_FULL)  state_d = RUN;
         end
         RUN: begin
            if (bad_frame || bus.mute_req) state_d = RAMP_DOWN;
         end
         RAMP_DOWN: begin
            if (gain_d == '0) begin
               if (!locked_d)         state_d = ACQUIRE;
               else if (bus.mute_req) state_d = MUTED;
               else                   state_d = RAMP_UP;
            end
         end
         MUTED: begin
            if (bad_frame)                         state_d = ACQUIRE;
            else if (!bus.mute_req && locked_q)    state_d = RAMP_UP;
         end
         default: state_d = IDLE;
      endcase
   end

   // FSM state and gain registers.
   always_ff @(posedge bclk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         gain_q  <= '0;
      end else begin
         state_q <= state_d;
         gain_q  <= gain_d;
      end
   end

   // 24-bit signed sample times 9-bit unsigned gain in a 33-bit signed product.
   assign in_l_x = {{9{bus.in_L[23]}}, bus.in_L};
   assign in_r_x = {{9{bus.in_R[23]}}, bus.in_R};
   assign gain_x = {24'd0, gain_q};
   assign prod_l = in_l_x * gain_x;
   assign prod_r = in_r_x * gain_x;
   assign unused_prod_bits = ^{prod_l[32], prod_l[7:0], prod_r[32], prod_r[7:0]};

   // Output sample registers, updated only on sample_valid.
   always_ff @(posedge bclk or negedge rst_n) begin
      if (!rst_n) begin
         out_l_q <= '0;
         out_r_q <= '0;
         ov_q    <= 1'b0;
      end else begin
         ov_q <= bus.sample_valid;
         if (bus.sample_valid) begin
            out_l_q <= prod_l[31:8];
            out_r_q <= prod_r[31:8];
         end
      end
   end

`ifdef DSD_STREAM_CTRL_ERRCNT_EN
   logic [15:0] errcnt_q;

   // Saturating count of bad frames, in step with frame_err.
   always_ff @(posedge bclk or negedge rst_n) begin
      if (!rst_n) begin
         errcnt_q <= '0;
      end else if (bad_frame && (errcnt_q != '1)) begin
         errcnt_q <= errcnt_q + 16'd1;
      end
   end

   assign bus.err_count = errcnt_q;
`endif

   assign bus.out_L     = out_l_q;
   assign bus.out_R     = out_r_q;
   assign bus.out_valid = ov_q;
   assign bus.locked    = locked_q;
   assign bus.state     = state_q;
   assign bus.frame_err = ferr_q;

endmodule

// File: tb/tb_dsd_stream_ctrl.sv
// Directed bench for dsd_stream_ctrl: ws framing generated cycle by cycle,
// expected gained samples queued per strobe and checked on out_valid.
module tb_dsd_stream_ctrl;

   typedef struct {
      logic [23:0] l;
      logic [23:0] r;
   } exp_t;

   logic bclk;
   logic rst_n;

   dsd_stream_ctrl_if bus ();

   dsd_stream_ctrl #(
      .FRAME_BCLK (64),
      .FRAME_TOL  (2),
      .LOCK_FRAMES(4),
      .RAMP_STEP  (1)
   ) dut (
      .bclk (bclk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   int   n_chk;
   int   n_fail;
   int   tick_no;
   int   ws_rises;
   int   last_rise_tick;
   int   err_seen;
   int   err_exp;
   int   ph;
   int   cur_p;
   int   ws_period;
   bit   ws_run;
   bit   ws_hold;
   int   per_q[$];
   exp_t sb_q[$];

   initial begin
      bclk = 1'b0;
      forever #5 bclk = ~bclk;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, %0d checks made", n_chk);
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [23:0] gmul(input logic signed [23:0] x, input int g);
      longint p;
      p = longint'(x) * longint'(g);
      p = p >>> 8;
      return p[23:0];
   endfunction

   // One bclk cycle: sample outputs at the falling edge, then drive ws.
   task automatic tick();
      exp_t e;
      @(negedge bclk);
      tick_no++;
      if (bus.frame_err === 1'b1) err_seen++;
      if (bus.out_valid === 1'b1) begin
         check("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
         if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check("out_L", 32'(bus.out_L), 32'(e.l));
            check("out_R", 32'(bus.out_R), 32'(e.r));
         end
      end
      if (!ws_run || ws_hold) begin
         bus.ws = 1'b0;
         ph = 0;
      end else begin
         if (ph == 0) begin
            cur_p = (per_q.size() != 0) ? per_q.pop_front() : ws_period;
            bus.ws = 1'b1;
            ws_rises++;
            last_rise_tick = tick_no;
         end else if (ph == cur_p / 2) begin
            bus.ws = 1'b0;
         end
         ph = (ph + 1 == cur_p) ? 0 : ph + 1;
      end
   endtask

   task automatic strobe(input logic [23:0] l, input logic [23:0] r, input int g);
      exp_t e;
      e.l = gmul(l, g);
      e.r = gmul(r, g);
      sb_q.push_back(e);
      bus.in_L = l;
      bus.in_R = r;
      bus.sample_valid = 1'b1;
      tick();
      bus.sample_valid = 1'b0;
      check("sb_drain", sb_q.size(), 32'd0);
      tick();
   endtask

   task automatic wait_state(input string tag, input logic [2:0] s, input int max);
      int n = 0;
      while (bus.state !== s && n < max) begin
         tick();
         n++;
      end
      check(tag, 32'(bus.state), 32'(s));
   endtask

   task automatic wait_lock(input string tag, input int max);
      int n = 0;
      while (bus.locked !== 1'b1 && n < max) begin
         tick();
         n++;
      end
      check(tag, 32'(bus.locked), 32'd1);
   endtask

   task automatic wait_err(input string tag, input int max);
      int base = err_seen;
      int n = 0;
      while (err_seen == base && n < max) begin
         tick();
         n++;
      end
      check(tag, err_seen - base, 32'd1);
   endtask

   initial begin
      int base;
      n_chk = 0; n_fail = 0; tick_no = 0; ws_rises = 0; last_rise_tick = 0;
      err_seen = 0; err_exp = 0; ph = 0; cur_p = 64; ws_period = 64;
      ws_run = 1'b0; ws_hold = 1'b0;
      rst_n = 1'b0;
      bus.ws = 1'b0; bus.sample_valid = 1'b0; bus.mute_req = 1'b0;
      bus.in_L = '0; bus.in_R = '0;

      // Reset state
      repeat (3) tick();
      check("rst_out_L", 32'(bus.out_L), 32'd0);
      check("rst_out_R", 32'(bus.out_R), 32'd0);
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_locked", 32'(bus.locked), 32'd0);
      check("rst_state", 32'(bus.state), 32'd0);
      check("rst_frame_err", 32'(bus.frame_err), 32'd0);
`ifdef DSD_STREAM_CTRL_ERRCNT_EN
      check("rst_err_count", 32'(bus.err_count), 32'd0);
`endif
      rst_n = 1'b1;
      tick();

      // Acquire and lock: first edge starts measurement, 4 good frames lock
      ws_run = 1'b1;
      wait_state("idle_to_acquire", 3'd1, 100);
      wait_lock("lock", 600);
      check("lock_on_5th_rise", ws_rises, 32'd5);
      wait_state("acquire_to_ramp_up", 3'd2, 10);

      // Ramp up, gain applied is the pre-update value
      for (int i = 0; i < 256; i++) strobe(24'h400000, 24'hA00000, i);
      check("ramp_up_to_run", 32'(bus.state), 32'd3);
      strobe(24'h400000, 24'h8ABCDE, 256);
      check("run_unity_L", 32'(bus.out_L), 32'h400000);
      check("run_unity_R", 32'(bus.out_R), 32'h8ABCDE);

      // Tolerance edges 66 and 62 accepted
      per_q.push_back(66);
      per_q.push_back(62);
      repeat (256) tick();
      check("tol_no_err", err_seen, err_exp);
      check("tol_still_run", 32'(bus.state), 32'd3);

      // Period 67 rejected: lock lost, ramp down to ACQUIRE
      per_q.push_back(67);
      wait_err("p67_err", 300);
      err_exp++;
      check("p67_unlocked", 32'(bus.locked), 32'd0);
      check("p67_ramp_down", 32'(bus.state), 32'd4);
      ws_hold = 1'b1;
      for (int i = 0; i < 256; i++) strobe(24'h400000, 24'h400000, 256 - i);
      err_exp++;
      check("rd_to_acquire", 32'(bus.state), 32'd1);
      strobe(24'h400000, 24'h400000, 0);
      check("acquire_out_zero", 32'(bus.out_L), 32'd0);
      check("err_after_p67", err_seen, err_exp);

      // Relock after the hold: 1 start edge + 4 good frames
      base = ws_rises;
      ws_hold = 1'b0;
      wait_lock("relock", 600);
      check("relock_rises", ws_rises - base, 32'd5);
      wait_state("relock_ramp_up", 3'd2, 10);
      for (int i = 0; i < 256; i++) strobe(24'h7FFFFF, 24'h800000, i);
      check("ramp2_to_run", 32'(bus.state), 32'd3);

      // Soft mute; a mute_req dip mid ramp-down does not abort it
      bus.mute_req = 1'b1;
      wait_state("mute_ramp_down", 3'd4, 10);
      for (int i = 0; i < 256; i++) begin
         if (i == 100) bus.mute_req = 1'b0;
         if (i == 110) bus.mute_req = 1'b1;
         strobe(24'h7FFFFF, 24'h7FFFFF, 256 - i);
      end
      check("muted", 32'(bus.state), 32'd5);
      strobe(24'h7FFFFF, 24'h7FFFFF, 0);
      check("muted_out_zero", 32'(bus.out_L), 32'd0);
      check("muted_locked", 32'(bus.locked), 32'd1);
      check("mute_no_err", err_seen, err_exp);
      bus.mute_req = 1'b0;
      wait_state("unmute_ramp_up", 3'd2, 10);
      for (int i = 0; i < 256; i++) strobe(24'h123456, 24'hFEDCBA, i);
      check("unmute_to_run", 32'(bus.state), 32'd3);

      // ws stuck low in RUN: single timeout at count 128
      ws_hold = 1'b1;
      wait_err("timeout_err", 300);
      err_exp++;
      check("timeout_gap", tick_no - last_rise_tick, 32'd129);
      check("timeout_ramp_down", 32'(bus.state), 32'd4);
      check("timeout_unlocked", 32'(bus.locked), 32'd0);
      for (int i = 0; i < 256; i++) strobe(24'h400000, 24'h400000, 256 - i);
      check("timeout_to_acquire", 32'(bus.state), 32'd1);
      check("timeout_single", err_seen, err_exp);
`ifdef DSD_STREAM_CTRL_ERRCNT_EN
      check("err_count", 32'(bus.err_count), err_exp);
`endif

      // Mid ramp-up at gain 128 with negative input, then async reset
      ws_hold = 1'b0;
      wait_lock("relock2", 600);
      wait_state("relock2_ramp_up", 3'd2, 10);
      for (int i = 0; i < 128; i++) strobe(24'h200000, 24'h600000, i);
      strobe(24'hC00000, 24'h400000, 128);
      check("gain128_L", 32'(bus.out_L), 32'hE00000);
      check("gain128_R", 32'(bus.out_R), 32'h200000);
      check("gain128_state", 32'(bus.state), 32'd2);
      #2 rst_n = 1'b0;
      #1;
      check("arst_out_L", 32'(bus.out_L), 32'd0);
      check("arst_out_R", 32'(bus.out_R), 32'd0);
      check("arst_out_valid", 32'(bus.out_valid), 32'd0);
      check("arst_locked", 32'(bus.locked), 32'd0);
      check("arst_state", 32'(bus.state), 32'd0);
      check("arst_frame_err", 32'(bus.frame_err), 32'd0);
`ifdef DSD_STREAM_CTRL_ERRCNT_EN
      check("arst_err_count", 32'(bus.err_count), 32'd0);
`endif
      sb_q.delete();
      ws_run = 1'b0;
      tick();
      rst_n = 1'b1;
      repeat (4) tick();
      check("post_rst_idle", 32'(bus.state), 32'd0);
      check("sb_final_empty", sb_q.size(), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
